// File: rtl/wave_ram_arbiter.sv
// Single-port waveform RAM arbiter: display reads take priority, capture writes queue in a FIFO.
// Define WAVE_ARB_STARVE_EN to add the starvation guard that forces a queued write through.
module wave_ram_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_WAIT   = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_req,
    input  logic [8:0]                    wr_addr,
    input  logic [7:0]                    wr_data,
    output logic                          wr_full,
    output logic                          wr_ovf,
    input  logic                          ovf_clr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    input  logic                          rd_req,
    input  logic [8:0]                    rd_addr,
    output logic                          rd_ready,
    output logic                          rd_valid,
    output logic [7:0]                    rd_data,
    output logic [8:0]                    ram_addr,
    output logic                          ram_we,
    output logic [7:0]                    ram_wdata,
    input  logic [7:0]                    ram_rdata
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {GNT_NONE, GNT_RD, GNT_WR} gnt_t;

    gnt_t          r_state;
    logic [8:0]    r_fifo_addr [FIFO_DEPTH];
    logic [7:0]    r_fifo_data [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_level;
    logic          r_ovf;

    logic w_empty;
    logic w_full;
    logic w_force;
    logic w_rd_gnt;
    logic w_pop;
    logic w_push;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == DEPTH_L);

`ifdef WAVE_ARB_STARVE_EN
    localparam logic [7:0] MAX_WAIT_L = 8'(MAX_WAIT);

    logic [7:0] r_wait;
    logic       w_starve;

    assign w_starve = (r_wait == MAX_WAIT_L);
    assign w_force  = w_starve & ~w_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wait <= 8'd0;
        end else if (w_pop || w_empty) begin
            r_wait <= 8'd0;
        end else if (!w_starve) begin
            r_wait <= r_wait + 8'd1;
        end
    end
`else
    assign w_force = 1'b0;
`endif

    // A forced write steals the slot even from an active read request.
    assign rd_ready = ~w_force;
    assign w_rd_gnt = rd_req & ~w_force;
    assign w_pop    = ~w_empty & (w_force | ~rd_req);
    assign w_push   = wr_req & (~w_full | w_pop);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        ram_addr  = 9'd0;
        ram_we    = 1'b0;
        ram_wdata = 8'd0;
        if (w_pop) begin
            ram_we    = 1'b1;
            ram_addr  = r_fifo_addr[r_rptr];
            ram_wdata = r_fifo_data[r_rptr];
        end else if (w_rd_gnt) begin
            ram_addr = rd_addr;
        end
    end

    // NOTE: queue storage carries no reset; the level/pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wptr] <= wr_addr;
            r_fifo_data[r_wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_ovf   <= 1'b0;
            r_state <= GNT_NONE;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (wr_req && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
            r_state <= w_pop ? GNT_WR : (w_rd_gnt ? GNT_RD : GNT_NONE);
        end
    end

    assign wr_full    = w_full;
    assign wr_ovf     = r_ovf;
    assign fifo_level = r_level;
    assign rd_valid   = (r_state == GNT_RD);
    assign rd_data    = rd_valid ? ram_rdata : 8'd0;

endmodule

// File: tb/tb_wave_ram_arbiter.sv
// Scoreboard bench for wave_ram_arbiter: stimulus queues expected reads/writes with their cycle,
// a negedge monitor pops and compares whenever rd_valid or ram_we is presented.
module tb_wave_ram_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_req = 1'b0;
    logic [8:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       wr_full;
    logic       wr_ovf;
    logic       ovf_clr = 1'b0;
    logic [2:0] fifo_level;
    logic       rd_req = 1'b0;
    logic [8:0] rd_addr = '0;
    logic       rd_ready;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic [8:0] ram_addr;
    logic       ram_we;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata = '0;

    typedef struct { int cyc; logic [7:0] data; } rd_exp_t;
    typedef struct { int cyc; logic [8:0] addr; logic [7:0] data; } wr_exp_t;

    rd_exp_t exp_rd[$];
    wr_exp_t exp_wr[$];

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    logic rd_expect = 1'b1;
    int   base;

    wave_ram_arbiter #(.FIFO_DEPTH(4), .MAX_WAIT(8)) dut (
        .clk(clk), .reset(reset),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_full(wr_full), .wr_ovf(wr_ovf), .ovf_clr(ovf_clr), .fifo_level(fifo_level),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM stand-in: read data is the low address byte, one cycle after the address.
    always @(posedge clk) ram_rdata <= ram_addr[7:0];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic [8:0] ra, input logic wr,
                         input logic [8:0] wa, input logic [7:0] wd, input logic clr);
        @(posedge clk);
        #1;
        rd_req  = rd;
        rd_addr = ra;
        wr_req  = wr;
        wr_addr = wa;
        wr_data = wd;
        ovf_clr = clr;
        if (rd && rd_expect) exp_rd.push_back('{cyc: cyc + 1, data: ra[7:0]});
    endtask

    task automatic idle();
        drive(1'b0, 9'd0, 1'b0, 9'd0, 8'd0, 1'b0);
    endtask

    always @(negedge clk) begin
        rd_exp_t re;
        wr_exp_t we;
        if (exp_rd.size() > 0 && exp_rd[0].cyc < cyc) begin
            re = exp_rd.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL rd_missing: no rd_valid seen, required at cycle %0d", re.cyc);
        end
        if (exp_wr.size() > 0 && exp_wr[0].cyc < cyc) begin
            we = exp_wr.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL wr_missing: no ram_we seen, required at cycle %0d addr %0h", we.cyc, we.addr);
        end
        if (rd_valid === 1'b1) begin
            if (exp_rd.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rd_unexpected: rd_valid=1 at cycle %0d, required 0", cyc);
            end else begin
                re = exp_rd.pop_front();
                check("rd_cycle", cyc, re.cyc);
                check("rd_data", {24'd0, rd_data}, {24'd0, re.data});
            end
        end else if (rd_valid === 1'b0 && reset === 1'b1) begin
            check("rd_data_idle", {24'd0, rd_data}, 32'd0);
        end
        if (ram_we === 1'b1) begin
            if (exp_wr.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL wr_unexpected: ram_we=1 at cycle %0d addr %0h, required 0", cyc, ram_addr);
            end else begin
                we = exp_wr.pop_front();
                check("wr_cycle", cyc, we.cyc);
                check("wr_addr", {23'd0, ram_addr}, {23'd0, we.addr});
                check("wr_data", {24'd0, ram_wdata}, {24'd0, we.data});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with random inputs.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            rd_req  = 1'($urandom);
            rd_addr = 9'($urandom);
            wr_req  = 1'($urandom);
            wr_addr = 9'($urandom);
            wr_data = 8'($urandom);
            ovf_clr = 1'($urandom);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        rd_req = 1'b0; rd_addr = '0; wr_req = 1'b0; wr_addr = '0; wr_data = '0; ovf_clr = 1'b0;
        @(negedge clk);
        check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_rd_data", {24'd0, rd_data}, 32'd0);
        check("rst_ram_we", {31'd0, ram_we}, 32'd0);
        check("rst_ram_addr", {23'd0, ram_addr}, 32'd0);
        check("rst_ram_wdata", {24'd0, ram_wdata}, 32'd0);
        check("rst_wr_full", {31'd0, wr_full}, 32'd0);
        check("rst_wr_ovf", {31'd0, wr_ovf}, 32'd0);
        check("rst_fifo_level", {29'd0, fifo_level}, 32'd0);
        check("rst_rd_ready", {31'd0, rd_ready}, 32'd1);

        // Idle write: visible on the RAM port the next cycle.
        drive(1'b0, 9'd0, 1'b1, 9'h123, 8'hA5, 1'b0);
        exp_wr.push_back('{cyc: cyc + 1, addr: 9'h123, data: 8'hA5});
        idle();
        @(negedge clk);
        check("idle_level_queued", {29'd0, fifo_level}, 32'd1);
        idle();
        @(negedge clk);
        check("idle_level_drained", {29'd0, fifo_level}, 32'd0);

        // Back-to-back read stream 0..9.
        for (int i = 0; i < 10; i++) drive(1'b1, 9'(i), 1'b0, 9'd0, 8'd0, 1'b0);
        idle();
        idle();

        // Overflow: five pushes under continuous reads.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 9'(64 + i), 1'b1, 9'(256 + i), 8'(16 + i), 1'b0);
            @(negedge clk);
            if (i == 3) check("ovf_not_full_3", {31'd0, wr_full}, 32'd0);
            if (i == 4) begin
                check("ovf_full_4", {31'd0, wr_full}, 32'd1);
                check("ovf_not_yet", {31'd0, wr_ovf}, 32'd0);
            end
        end
        drive(1'b1, 9'h045, 1'b0, 9'd0, 8'd0, 1'b0);
        @(negedge clk);
        check("ovf_set", {31'd0, wr_ovf}, 32'd1);
        check("ovf_level", {29'd0, fifo_level}, 32'd4);
        check("ovf_full", {31'd0, wr_full}, 32'd1);
        drive(1'b1, 9'h046, 1'b0, 9'd0, 8'd0, 1'b1);
        @(negedge clk);
        check("ovf_held_during_clr", {31'd0, wr_ovf}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            idle();
            exp_wr.push_back('{cyc: cyc, addr: 9'(256 + i), data: 8'(16 + i)});
            @(negedge clk);
            if (i == 0) check("ovf_cleared", {31'd0, wr_ovf}, 32'd0);
        end
        idle();
        @(negedge clk);
        check("ovf_drained_level", {29'd0, fifo_level}, 32'd0);

        // Full queue plus same-cycle pop, across pointer wrap.
        for (int i = 0; i < 4; i++) drive(1'b1, 9'(80 + i), 1'b1, 9'(128 + i), 8'(160 + i), 1'b0);
        drive(1'b0, 9'd0, 1'b1, 9'h0FF, 8'hEE, 1'b0);
        base = cyc;
        for (int i = 0; i < 4; i++) exp_wr.push_back('{cyc: base + i, addr: 9'(128 + i), data: 8'(160 + i)});
        exp_wr.push_back('{cyc: base + 4, addr: 9'h0FF, data: 8'hEE});
        @(negedge clk);
        check("fullpop_full", {31'd0, wr_full}, 32'd1);
        idle();
        @(negedge clk);
        check("fullpop_level", {29'd0, fifo_level}, 32'd4);
        check("fullpop_no_ovf", {31'd0, wr_ovf}, 32'd0);
        for (int i = 0; i < 3; i++) idle();
        idle();
        @(negedge clk);
        check("fullpop_drained", {29'd0, fifo_level}, 32'd0);

        // Starvation under continuous reads with one queued write.
        for (int i = 0; i < 12; i++) begin
`ifdef WAVE_ARB_STARVE_EN
            rd_expect = (i != 9);
`endif
            drive(1'b1, 9'(96 + i), (i == 0), 9'h1AB, 8'h5C, 1'b0);
`ifdef WAVE_ARB_STARVE_EN
            if (i == 9) exp_wr.push_back('{cyc: cyc, addr: 9'h1AB, data: 8'h5C});
`endif
            @(negedge clk);
            check("starve_rd_ready", {31'd0, rd_ready}, {31'd0, rd_expect});
            rd_expect = 1'b1;
        end
`ifndef WAVE_ARB_STARVE_EN
        idle();
        exp_wr.push_back('{cyc: cyc, addr: 9'h1AB, data: 8'h5C});
`endif
        idle();
        idle();

        // Reset mid-operation: queued write discarded, in-flight read suppressed.
        rd_expect = 1'b0;
        drive(1'b1, 9'h033, 1'b1, 9'h1CC, 8'h77, 1'b0);
        rd_expect = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        rd_req = 1'b0; rd_addr = '0; wr_req = 1'b0; wr_addr = '0; wr_data = '0; ovf_clr = 1'b0;
        @(negedge clk);
        check("midrst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("midrst_level", {29'd0, fifo_level}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) idle();
        @(negedge clk);
        check("midrst_level_after", {29'd0, fifo_level}, 32'd0);

        idle();
        idle();
        @(negedge clk);
        check("rd_queue_drained", exp_rd.size(), 32'd0);
        check("wr_queue_drained", exp_wr.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
